// File: rtl/tile_sequencer_if.sv
// Router-side handshake bundle for tile_sequencer.
// master = sequencer, slave = input/weight/output routers and psum array.
interface tile_sequencer_if #(
  parameter int COL_COUNT = 4
);
  logic                 o_ir_en;
  logic                 o_ir_pop_en;
  logic                 i_ir_ready;
  logic                 i_ir_done;
  logic [COL_COUNT-1:0] o_wr_en;
  logic [COL_COUNT-1:0] o_wr_pop_en;
  logic [COL_COUNT-1:0] i_wr_ready;
  logic [COL_COUNT-1:0] i_wr_done;
  logic                 o_psum_out_en;
  logic                 o_array_clear;
  logic                 o_or_en;
  logic                 i_or_done;

  modport master (
    output o_ir_en, o_ir_pop_en,
    output o_wr_en, o_wr_pop_en,
    output o_psum_out_en, o_array_clear, o_or_en,
    input  i_ir_ready, i_ir_done,
    input  i_wr_ready, i_wr_done,
    input  i_or_done
  );

  modport slave (
    input  o_ir_en, o_ir_pop_en,
    input  o_wr_en, o_wr_pop_en,
    input  o_psum_out_en, o_array_clear, o_or_en,
    output i_ir_ready, i_ir_done,
    output i_wr_ready, i_wr_done,
    output i_or_done
  );
endinterface

// File: rtl/tile_sequencer.sv
// Tile sequencer: load, stream, drain, output per tile, then done.
// Define TILE_PERF_CNT_EN to add the o_stall_cycles stall counter.
module tile_sequencer #(
  parameter int ROUTER_COUNT = 8,
  parameter int COL_COUNT    = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int SPAD_COUNT   = 2,
  localparam int SEL_W =
    (SPAD_COUNT > 1) ? $clog2(SPAD_COUNT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reg_clear,
  input  logic                  i_write_en,
  input  logic [SEL_W-1:0]      i_spad_select,
  output logic [SPAD_COUNT-1:0] o_spad_write_en,
  input  logic                  i_route_en,
  input  logic [ADDR_WIDTH-1:0] i_tile_count,
  input  logic [ADDR_WIDTH-1:0] i_route_size,
  tile_sequencer_if.master      rtr,
  output logic [ADDR_WIDTH-1:0] o_tile_idx,
  output logic                  o_busy,
  output logic                  o_done
`ifdef TILE_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cycles
`endif
);

  localparam int DW = $clog2(ROUTER_COUNT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] OUTPUT = 3'd4;
  localparam logic [2:0] NEXT   = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] tile_cnt;
  logic [ADDR_WIDTH-1:0] size;
  logic [ADDR_WIDTH-1:0] pop_cnt;
  logic [DW-1:0]         drn_cnt;
  logic                  all_rdy;
  logic                  pop;
  logic                  unused_done;

  always_comb begin
    o_spad_write_en = '0;
    for (int i = 0; i < SPAD_COUNT; i++)
      if (i_spad_select == SEL_W'(i))
        o_spad_write_en[i] = i_write_en;
  end

  // done inputs are status only; they never steer the FSM
  assign unused_done = ^{rtr.i_ir_done, rtr.i_wr_done};

  assign all_rdy = rtr.i_ir_ready & (&rtr.i_wr_ready);
  assign pop     = (state == STREAM) & all_rdy;

  assign rtr.o_ir_en       = (state == LOAD);
  assign rtr.o_wr_en       = {COL_COUNT{state == LOAD}};
  assign rtr.o_ir_pop_en   = pop;
  assign rtr.o_wr_pop_en   = {COL_COUNT{pop}};
  assign rtr.o_psum_out_en = (state == DRAIN);
  assign rtr.o_or_en       = (state == OUTPUT);
  assign rtr.o_array_clear = (state == NEXT);
  assign o_busy            = (state != IDLE);
  assign o_done            = (state == DONE);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= IDLE;
      tile_cnt   <= '0;
      size       <= '0;
      pop_cnt    <= '0;
      drn_cnt    <= '0;
      o_tile_idx <= '0;
    end else if (i_reg_clear) begin
      state      <= IDLE;
      pop_cnt    <= '0;
      drn_cnt    <= '0;
      o_tile_idx <= '0;
    end else begin
      unique case (state)
        IDLE: if (i_route_en) begin
          tile_cnt   <= i_tile_count;
          size       <= i_route_size;
          o_tile_idx <= '0;
          pop_cnt    <= '0;
          drn_cnt    <= '0;
          state      <= (i_tile_count == '0) ? DONE : LOAD;
        end
        LOAD: if (all_rdy)
          state <= (size == '0) ? DRAIN : STREAM;
        STREAM: if (all_rdy) begin
          if (pop_cnt == size - 1'b1) begin
            pop_cnt <= '0;
            state   <= DRAIN;
          end else begin
            pop_cnt <= pop_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drn_cnt == DW'(ROUTER_COUNT - 1)) begin
            drn_cnt <= '0;
            state   <= OUTPUT;
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        OUTPUT: if (rtr.i_or_done)
          state <= NEXT;
        NEXT: begin
          if (o_tile_idx == tile_cnt - 1'b1) begin
            state <= DONE;
          end else begin
            o_tile_idx <= o_tile_idx + 1'b1;
            state      <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TILE_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)
      o_stall_cycles <= '0;
    else if (i_reg_clear)
      o_stall_cycles <= '0;
    else if (state == IDLE && i_route_en)
      o_stall_cycles <= '0;
    else if (state == STREAM && !all_rdy && o_stall_cycles != '1)
      o_stall_cycles <= o_stall_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Randomized bench for tile_sequencer against a transaction-level model.
// Optional TILE_PERF_CNT_EN also checks o_stall_cycles.
module tb_tile_sequencer;
  localparam int RC = 8;
  localparam int CC = 4;
  localparam int AW = 8;

  logic          clk = 0;
  logic          nrst = 0;
  logic          reg_clear = 0;
  logic          write_en = 0;
  logic          route_en = 0;
  logic [0:0]    spad_sel = '0;
  logic [1:0]    spad_sel3 = '0;
  logic [1:0]    spad_we;
  logic [2:0]    spad_we3;
  logic [AW-1:0] tile_count = '0;
  logic [AW-1:0] route_size = '0;
  logic [AW-1:0] tile_idx, tile_idx3;
  logic          busy, done, busy3, done3;
`ifdef TILE_PERF_CNT_EN
  logic [31:0]   stall_cycles, stall3;
`endif

  tile_sequencer_if #(.COL_COUNT(CC)) bus ();
  tile_sequencer_if #(.COL_COUNT(CC)) bus3 ();

  tile_sequencer #(
    .ROUTER_COUNT(RC), .COL_COUNT(CC),
    .ADDR_WIDTH(AW), .SPAD_COUNT(2)
  ) u_dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_reg_clear(reg_clear),
    .i_write_en(write_en),
    .i_spad_select(spad_sel),
    .o_spad_write_en(spad_we),
    .i_route_en(route_en),
    .i_tile_count(tile_count),
    .i_route_size(route_size),
    .rtr(bus),
    .o_tile_idx(tile_idx),
    .o_busy(busy), .o_done(done)
`ifdef TILE_PERF_CNT_EN
    , .o_stall_cycles(stall_cycles)
`endif
  );

  tile_sequencer #(
    .ROUTER_COUNT(RC), .COL_COUNT(CC),
    .ADDR_WIDTH(AW), .SPAD_COUNT(3)
  ) u_dut3 (
    .i_clk(clk), .i_nrst(nrst),
    .i_reg_clear(1'b0),
    .i_write_en(write_en),
    .i_spad_select(spad_sel3),
    .o_spad_write_en(spad_we3),
    .i_route_en(1'b0),
    .i_tile_count('0),
    .i_route_size('0),
    .rtr(bus3),
    .o_tile_idx(tile_idx3),
    .o_busy(busy3), .o_done(done3)
`ifdef TILE_PERF_CNT_EN
    , .o_stall_cycles(stall3)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int tiles, input int sz,
                     input int pct, input int or_dly,
                     input int hold);
    int pops = 0, wins = 0, win_len = 0;
    int or_cnt = 0, or_wins = 0, dones = 0;
    int done_cyc = -1, stalls = 0, tpops = 0, held = 0;
    logic in_stream = 0, prev_ir = 0, prev_psum = 0;
    logic all_rdy, exp_pop;
    int idx_q[$];
    tile_count = AW'(tiles);
    route_size = AW'(sz);
    route_en = 1;
    @(posedge clk); #1;
    route_en = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.i_ir_ready = ($urandom_range(99) < pct);
      for (int k = 0; k < CC; k++)
        bus.i_wr_ready[k] = ($urandom_range(99) < pct);
      if (in_stream && tpops == 1 && held < hold) begin
        bus.i_wr_ready[2] = 1'b0;
        held++;
      end
      bus.i_ir_done = 1'($urandom);
      bus.i_wr_done = CC'($urandom);
      bus.i_or_done = (or_cnt >= or_dly);
      #1;
      all_rdy = bus.i_ir_ready & (&bus.i_wr_ready);
      if (prev_ir && !bus.o_ir_en && sz > 0) in_stream = 1;
      if (in_stream && !all_rdy) stalls++;
      exp_pop = in_stream & all_rdy;
      check("pop_en", {bus.o_ir_pop_en, bus.o_wr_pop_en},
            {(CC+1){exp_pop}});
      if (exp_pop) begin
        pops++;
        tpops++;
        if (tpops == sz) begin
          in_stream = 0;
          tpops = 0;
        end
      end
      if (bus.o_ir_en) check("load_wr_en", bus.o_wr_en, {CC{1'b1}});
      if (bus.o_psum_out_en) begin
        if (!prev_psum) idx_q.push_back(int'(tile_idx));
        win_len++;
      end else if (prev_psum) begin
        check("psum_len", win_len, RC);
        wins++;
        win_len = 0;
      end
      if (bus.o_or_en) or_cnt++;
      else begin
        if (or_cnt > 0) or_wins++;
        or_cnt = 0;
      end
      if (done) begin
        dones++;
        done_cyc = c;
        check("busy_at_done", busy, 1);
      end
      prev_ir = bus.o_ir_en;
      prev_psum = bus.o_psum_out_en;
      if (dones > 0 && c >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    check("done_cnt", dones, 1);
    check("pops", pops, tiles * sz);
    check("psum_wins", wins, tiles);
    check("or_wins", or_wins, tiles);
    foreach (idx_q[i]) check("win_tile_idx", idx_q[i], i);
    if (tiles > 0) check("last_tile_idx", tile_idx, tiles - 1);
    if (tiles == 0) check("zero_done_lat", done_cyc, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
`ifdef TILE_PERF_CNT_EN
    check("stall_cycles", stall_cycles, stalls);
`endif
  endtask

  initial begin
    int sel;
    logic seen;
    bus.i_ir_ready = 0; bus.i_ir_done = 0;
    bus.i_wr_ready = '0; bus.i_wr_done = '0;
    bus.i_or_done = 0;
    bus3.i_ir_ready = 0; bus3.i_ir_done = 0;
    bus3.i_wr_ready = '0; bus3.i_wr_done = '0;
    bus3.i_or_done = 0;
    write_en = 1;
    spad_sel = 1'b1;
    spad_sel3 = 2'd3;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tile_idx", tile_idx, 0);
    check("rst_ir_en", bus.o_ir_en, 0);
    check("rst_psum", bus.o_psum_out_en, 0);
    check("rst_spad_we", spad_we, 2'b10);
    check("spad3_sel3", spad_we3, 3'b000);
    #9 nrst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      write_en = 1'($urandom);
      sel = $urandom_range(3);
      spad_sel = 1'(sel);
      spad_sel3 = 2'(sel);
      #1;
      check("spad_we", spad_we,
            write_en ? (2'b01 << (sel % 2)) : 2'b00);
      check("spad_we3", spad_we3,
            (write_en && sel < 3) ? (3'b001 << sel) : 3'b000);
    end
    write_en = 0;

    run(2, 4, 100, 2, 0);
    run(1, 3, 100, 1, 2);
    run(0, 5, 100, 1, 0);
    for (int i = 0; i < 6; i++)
      run($urandom_range(1, 3), $urandom_range(0, 5),
          85, $urandom_range(0, 3), 0);

    // soft clear while draining, with a competing start pulse
    bus.i_ir_ready = 1;
    bus.i_wr_ready = '1;
    bus.i_or_done = 0;
    tile_count = 2;
    route_size = 2;
    route_en = 1;
    @(posedge clk); #1;
    route_en = 0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk); #1;
      seen = bus.o_psum_out_en;
    end
    check("clr_reach_drain", seen, 1);
    reg_clear = 1;
    route_en = 1;
    @(posedge clk); #1;
    reg_clear = 0;
    route_en = 0;
    check("clr_busy", busy, 0);
    check("clr_psum", bus.o_psum_out_en, 0);
    check("clr_tile_idx", tile_idx, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    check("clr_quiet", seen, 0);
    run(1, 2, 100, 1, 0);

    // asynchronous reset in the middle of streaming
    bus.i_ir_ready = 1;
    bus.i_wr_ready = '1;
    tile_count = 1;
    route_size = 30;
    route_en = 1;
    @(posedge clk); #1;
    route_en = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      seen = bus.o_ir_pop_en;
    end
    check("rst_reach_stream", seen, 1);
    #2 nrst = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_pop", {bus.o_ir_pop_en, bus.o_wr_pop_en}, 0);
    check("arst_ir_en", bus.o_ir_en, 0);
    check("arst_tile_idx", tile_idx, 0);
`ifdef TILE_PERF_CNT_EN
    check("arst_stall", stall_cycles, 0);
`endif
    #2 nrst = 1;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have parameter ROUTER_COUNT, default 8: rows per column and psum drain length in cycles.
REQ-002 SHALL have parameter COL_COUNT, default 4: number of weight-router/array columns sequenced in lockstep.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: width of size/count/index ports.
REQ-004 SHALL have parameter SPAD_COUNT, default 2: scratchpads addressable by host; SEL_W = max(1, clog2(SPAD_COUNT)).
REQ-005 SHALL have ports i_clk (in, 1, clock) and i_nrst (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-006 SHALL have i_reg_clear (in, 1): synchronous soft clear.
REQ-007 SHALL have i_write_en (in, 1) and i_spad_select (in, SEL_W): host write strobe and target scratchpad.
REQ-008 SHALL have o_spad_write_en (out, SPAD_COUNT): one-hot write enable per scratchpad.
REQ-009 SHALL have i_route_en (in, 1) start pulse, i_tile_count (in, ADDR_WIDTH) and i_route_size (in, ADDR_WIDTH) pops per tile.
REQ-010 SHALL have o_ir_en, o_ir_pop_en (out, 1) and i_ir_ready, i_ir_done (in, 1) for the input router.
REQ-011 SHALL have o_wr_en, o_wr_pop_en (out, COL_COUNT) and i_wr_ready, i_wr_done (in, COL_COUNT) for weight routers.
REQ-012 SHALL have o_psum_out_en, o_array_clear, o_or_en (out, 1) and i_or_done (in, 1).
REQ-013 SHALL have o_tile_idx (out, ADDR_WIDTH), o_busy (out, 1), o_done (out, 1).

Function
REQ-014 o_spad_write_en SHALL be combinational: bit i_spad_select = i_write_en, all other bits 0; select >= SPAD_COUNT gives all zeros; forwarded in every state.
REQ-015 FSM states SHALL be IDLE, LOAD, STREAM, DRAIN, OUTPUT, NEXT, DONE; o_busy = 1 in all states except IDLE.
REQ-016 IDLE: on i_route_en, latch i_tile_count and i_route_size, clear o_tile_idx; go LOAD, or DONE if latched tile_count = 0; i_route_en outside IDLE SHALL be ignored.
REQ-017 LOAD: o_ir_en = 1 and all o_wr_en bits = 1 until i_ir_ready = 1 and &i_wr_ready = 1, then STREAM (or DRAIN if route_size = 0).
REQ-018 STREAM: o_ir_pop_en and all o_wr_pop_en bits SHALL be 1 only in cycles where i_ir_ready and &i_wr_ready; pop counter increments per pop; after route_size pops go DRAIN.
REQ-019 A cycle in STREAM without all-ready SHALL be a stall: no pop, counter held.
REQ-020 DRAIN: o_psum_out_en = 1 for exactly ROUTER_COUNT cycles, then OUTPUT.
REQ-021 OUTPUT: o_or_en = 1 until i_or_done sampled 1, then NEXT.
REQ-022 NEXT: o_array_clear = 1 for one cycle; if o_tile_idx = tile_count-1 go DONE, else o_tile_idx increments and go LOAD.
REQ-023 DONE: o_done = 1 for exactly one cycle, then IDLE; o_tile_idx holds last value.
REQ-024 i_ir_done / i_wr_done SHALL be ignored by sequencing (status only); counters SHALL be ADDR_WIDTH wide with no wrap beyond latched limits.

Reset
REQ-025 On i_nrst low: state IDLE, counters, latched sizes and o_tile_idx 0; all registered outputs 0; o_spad_write_en still follows REQ-014.
REQ-026 i_reg_clear = 1 SHALL on the next edge force IDLE and zero all counters, overriding i_route_en; mid-run clear SHALL not produce o_done.

Configuration
REQ-027 With TILE_PERF_CNT_EN defined: add o_stall_cycles (out, 32), counting REQ-019 stall cycles, saturating at all-ones, cleared on reset, i_reg_clear and run start.
REQ-028 Without TILE_PERF_CNT_EN: port o_stall_cycles and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 i_write_en=1, i_spad_select=1, SPAD_COUNT=2 -> o_spad_write_en=2'b10; select=3 (SPAD_COUNT=3) -> 3'b000.
REQ-030 tile_count=2, route_size=4, readies always 1, i_or_done 2 cycles after o_or_en -> 8 total pop cycles, two 8-cycle psum_out windows, o_tile_idx 0 then 1, one o_done pulse.
REQ-031 route_size=3, i_wr_ready[2] low 2 cycles mid-STREAM -> exactly 3 pop cycles, pops suppressed during stall; with TILE_PERF_CNT_EN o_stall_cycles=2.
REQ-032 i_route_en with tile_count=0 -> LOAD never entered, o_done=1 exactly one cycle after start, o_busy high that cycle only.
REQ-033 i_reg_clear asserted during DRAIN -> IDLE next cycle, o_psum_out_en=0, o_done never asserted; new i_route_en restarts at tile 0.
REQ-034 i_nrst asserted asynchronously mid-STREAM -> all registered outputs 0 immediately, no clock edge required.
